// File: rtl/uart_tx_streamer_if.sv
// Buffer-side bundle of the UART TX streamer: write strobe, async read data/address, line and status.
// The master modport is the TX buffer / CPU side; the slave modport is the streamer.
interface uart_tx_streamer_if;
    logic       wr_pulse;
    logic [7:0] data_tx;
    logic [3:0] rd_addr;
    logic       uart_tx_0;
    logic       busy;
    logic       overflow;

    modport master (
        output wr_pulse, data_tx,
        input  rd_addr, uart_tx_0, busy, overflow
    );

    modport slave (
        input  wr_pulse, data_tx,
        output rd_addr, uart_tx_0, busy, overflow
    );
endinterface

// File: rtl/uart_tx_streamer.sv
// Drains the circular TX buffer as back-to-back 8N1 frames; line falls 2 edges after a write.
// No backpressure: writes beyond DEPTH pending bytes are dropped from the count and flagged sticky.
module uart_tx_streamer #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DEPTH        = 13
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_streamer_if.slave  bus
);
    localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     DEPTH_L   = 4'(DEPTH);
    localparam logic [3:0]     ADDR_LAST = 4'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cyc_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic [3:0]      pending;
    logic [3:0]      rd_addr;
    logic            tx;
    logic            ovf;
    logic            bit_end;
    logic            frame_done;

    assign bit_end    = (cyc_cnt == CNT_LAST);
    assign frame_done = (state == STOP) && bit_end;

    assign bus.rd_addr   = rd_addr;
    assign bus.uart_tx_0 = tx;
    assign bus.overflow  = ovf;
    assign bus.busy      = (state != IDLE) || (pending != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cyc_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            pending <= '0;
            rd_addr <= '0;
            tx      <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            // A write coinciding with frame completion leaves the count unchanged.
            if (bus.wr_pulse && !frame_done) begin
                if (pending == DEPTH_L)
                    ovf <= 1'b1;
                else
                    pending <= pending + 4'd1;
            end else if (!bus.wr_pulse && frame_done) begin
                pending <= pending - 4'd1;
            end

            case (state)
                IDLE: begin
                    if (pending != 4'd0) begin
                        shift   <= bus.data_tx;
                        tx      <= 1'b0;
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        shift   <= {1'b0, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        rd_addr <= (rd_addr == ADDR_LAST) ? 4'd0 : rd_addr + 4'd1;
                        state   <= IDLE;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_streamer.sv
// Directed bench for uart_tx_streamer: stimulus queues expected bytes, a line monitor decodes and scores frames.
module tb_uart_tx_streamer;
    localparam int CPB   = 4;
    localparam int DEPTH = 13;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    uart_tx_streamer_if bus ();

    uart_tx_streamer #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [16];
    int         wp = 0;
    int         wr_cyc = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    assign bus.data_tx = mem[bus.rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Caller must be at a negedge; issues one write pulse sampled at the next posedge.
    task automatic put(input logic [7:0] d, input bit push);
        mem[wp]      = d;
        wp           = (wp + 1) % DEPTH;
        bus.wr_pulse = 1'b1;
        wr_cyc       = cyc + 1;
        if (push) exp_q.push_back(d);
        @(negedge clk);
        bus.wr_pulse = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < budget), 1);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wp    = 0;
    endtask

    // Line monitor: every frame is checked cycle by cycle against the next expected byte.
    initial begin
        logic [9:0] frame;
        logic [7:0] expb;
        bit         got_exp, ok, aborted;
        forever begin
            @(negedge clk);
            if (!reset && bus.uart_tx_0 === 1'b0) begin
                start_q.push_back(cyc);
                got_exp = (exp_q.size() > 0);
                expb    = got_exp ? exp_q.pop_front() : 8'h00;
                frame   = {1'b1, expb, 1'b0};
                ok      = 1'b1;
                aborted = 1'b0;
                for (int i = 0; i < 10 * CPB && !aborted; i++) begin
                    if (i != 0) @(negedge clk);
                    if (reset) aborted = 1'b1;
                    else if (bus.uart_tx_0 !== frame[i / CPB]) ok = 1'b0;
                end
                if (!aborted) begin
                    checks++;
                    if (!got_exp || !ok) begin
                        failures++;
                        $display("FAIL frame: byte 0x%02h expected=%0d shape_ok=%0d required shape_ok=1",
                                 expb, got_exp, ok);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, n0, lows;
        bus.wr_pulse = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // Reset values
        reset_dut();
        check("rst_tx", bus.uart_tx_0, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_rd_addr", bus.rd_addr, 0);
        check("rst_overflow", bus.overflow, 0);

        // Reset 10 cycles into a frame
        put(8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tx", bus.uart_tx_0, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_rd_addr", bus.rd_addr, 0);
        reset = 1'b0;
        wp    = 0;
        lows  = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.uart_tx_0 !== 1'b1 || bus.busy !== 1'b0) lows++;
        end
        check("midrst_no_glitch", lows, 0);

        // Single byte 0x55
        put(8'h55, 1'b1);
        w0 = wr_cyc;
        repeat (40) @(negedge clk);
        check("single_busy_e40", bus.busy, 1);
        check("single_rd_addr_e40", bus.rd_addr, 0);
        @(negedge clk);
        check("single_busy_e41", bus.busy, 0);
        check("single_rd_addr_e41", bus.rd_addr, 1);
        check("single_start_latency", start_q[$] - w0, 1);

        // Burst of three consecutive writes
        reset_dut();
        n0 = start_q.size();
        put(8'hA5, 1'b1);
        put(8'h00, 1'b1);
        put(8'hFF, 1'b1);
        wait_idle(400, "burst_timeout");
        check("burst_frames", start_q.size() - n0, 3);
        check("burst_gap1", start_q[n0 + 1] - start_q[n0], 41);
        check("burst_gap2", start_q[n0 + 2] - start_q[n0 + 1], 41);
        check("burst_rd_addr", bus.rd_addr, 3);
        check("burst_pending", dut.pending, 0);

        // Wrap-around of rd_addr
        for (int i = 0; i < 9; i++) put(8'h10 + 8'(i), 1'b1);
        wait_idle(600, "wrap_timeout1");
        check("wrap_rd_addr_12", bus.rd_addr, 12);
        put(8'h3C, 1'b1);
        wait_idle(100, "wrap_timeout2");
        check("wrap_rd_addr_0", bus.rd_addr, 0);

        // Write on the final STOP cycle
        n0 = start_q.size();
        put(8'h81, 1'b1);
        w0 = wr_cyc;
        while (cyc < w0 + 40) @(negedge clk);
        put(8'h7E, 1'b1);
        check("simul_pending", dut.pending, 1);
        check("simul_busy", bus.busy, 1);
        check("simul_rd_addr", bus.rd_addr, 1);
        wait_idle(100, "simul_timeout");
        check("simul_frames", start_q.size() - n0, 2);
        check("simul_gap", start_q[n0 + 1] - start_q[n0], 41);
        check("simul_rd_addr_end", bus.rd_addr, 2);

        // Overflow: 14 writes with no time to drain
        for (int i = 0; i < 14; i++) put(8'hE0 + 8'(i), (i < 13));
        check("ovf_set", bus.overflow, 1);
        check("ovf_pending_sat", dut.pending, 13);
        wait_idle(700, "ovf_timeout");
        check("ovf_sticky", bus.overflow, 1);
        check("ovf_rd_addr", bus.rd_addr, 2);
        reset_dut();
        check("ovf_cleared", bus.overflow, 0);

        repeat (5) @(negedge clk);
        check("all_frames_seen", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
